// File: rtl/data_memory_unit_if.sv
// Data-memory bus between the core's execute stage and the data-memory unit.
//   master : drives addr_i, wdata_i, we_i, re_i and funct3_i, and receives rdata_o and fault_o
//   slave  : the memory unit, which receives the request and returns
//            the combinational load result and the access-fault flag
interface data_memory_unit_if #(
    parameter int BITNESS = 32
);
    logic [BITNESS-1:0] addr_i;
    logic [BITNESS-1:0] wdata_i;
    logic               we_i;
    logic               re_i;
    logic [2:0]         funct3_i;
    logic [BITNESS-1:0] rdata_o;
    logic               fault_o;

    modport master (
        output addr_i, wdata_i, we_i, re_i, funct3_i,
        input  rdata_o, fault_o
    );

    modport slave (
        input  addr_i, wdata_i, we_i, re_i, funct3_i,
        output rdata_o, fault_o
    );
endinterface

// File: rtl/data_memory_unit.sv
// Data-memory stage of the single-cycle RV32 core.
// Byte-addressed little-endian RAM with RV32I load/store widths, plus an
// MMIO window at addr[31:16] == MMIO_TAG:
//   +0x0 OUT    (RW, bits[7:0])
//   +0x4 CYCLE  (RO, free-running)
//   +0x8 STATUS (W1C, {bus_fault, misalign})
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : slave side of the data-memory bus (combinational read/fault)
//   mmio_out_o   : OUT register
//   status_o     : sticky status register
module data_memory_unit #(
    parameter int          BITNESS        = 32,
    parameter int          RAM_ADDR_WIDTH = 17,
    parameter logic [15:0] MMIO_TAG       = 16'hFFFF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    data_memory_unit_if.slave   bus,
    output logic [7:0]          mmio_out_o,
    output logic [1:0]          status_o
);
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int         WORDS = 2 ** (RAM_ADDR_WIDTH - 2);

    logic [BITNESS-1:0]        mem [WORDS];
    logic [RAM_ADDR_WIDTH-3:0] widx;
    logic [BITNESS-1:0]        ram_word;

    logic [7:0]         out_q;
    logic [BITNESS-1:0] cycle_q;
    logic [1:0]         status_q;

    logic access, f3_legal, misalign;
    logic is_ram, is_mmio, sel_out, sel_cyc, sel_st, mmio_hit;
    logic bus_err, mis_err, fault;
    logic wr_en, ram_we;
    logic [3:0]         be;
    logic [BITNESS-1:0] wlane;
    logic [BITNESS-1:0] rd_val;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [1:0]         w1c;

    // ---------------- decode ----------------
    assign access  = bus.re_i | bus.we_i;
    assign is_ram  = (bus.addr_i[BITNESS-1:RAM_ADDR_WIDTH] == '0);
    assign is_mmio = (bus.addr_i[BITNESS-1:16] == MMIO_TAG);
    assign sel_out = is_mmio && (bus.addr_i[15:0] == 16'h0000);
    assign sel_cyc = is_mmio && (bus.addr_i[15:0] == 16'h0004);
    assign sel_st  = is_mmio && (bus.addr_i[15:0] == 16'h0008);
    assign mmio_hit = sel_out | sel_cyc | sel_st;

    always_comb begin
        f3_legal = 1'b0;
        misalign = 1'b0;
        case (bus.funct3_i)
            F3_B, F3_BU: f3_legal = 1'b1;
            F3_H, F3_HU: begin
                f3_legal = 1'b1;
                misalign = bus.addr_i[0];
            end
            F3_W: begin
                f3_legal = 1'b1;
                misalign = (bus.addr_i[1:0] != 2'b00);
            end
            default: f3_legal = 1'b0;
        endcase
    end

    // Bus faults (illegal width, bad MMIO access, unmapped) take priority;
    // misalignment is only reported against RAM.
    assign bus_err = access & (~f3_legal
                             | (is_mmio & ((bus.funct3_i != F3_W) | ~mmio_hit))
                             | (~is_ram & ~is_mmio));
    assign mis_err = access & ~bus_err & is_ram & misalign;
    assign fault   = bus_err | mis_err;

    assign bus.fault_o = fault;

    // ---------------- read path ----------------
    assign widx     = bus.addr_i[RAM_ADDR_WIDTH-1:2];
    assign ram_word = mem[widx];
    assign rd_byte  = ram_word[{bus.addr_i[1:0], 3'b000} +: 8];
    assign rd_half  = ram_word[{bus.addr_i[1], 4'b0000} +: 16];

    always_comb begin
        rd_val = '0;
        if (is_ram) begin
            case (bus.funct3_i)
                F3_B:    rd_val = {{(BITNESS-8){rd_byte[7]}}, rd_byte};
                F3_BU:   rd_val = {{(BITNESS-8){1'b0}}, rd_byte};
                F3_H:    rd_val = {{(BITNESS-16){rd_half[15]}}, rd_half};
                F3_HU:   rd_val = {{(BITNESS-16){1'b0}}, rd_half};
                F3_W:    rd_val = ram_word;
                default: rd_val = '0;
            endcase
        end else if (sel_out) begin
            rd_val = BITNESS'(out_q);
        end else if (sel_cyc) begin
            rd_val = cycle_q;
        end else if (sel_st) begin
            rd_val = BITNESS'(status_q);
        end
    end

    assign bus.rdata_o = (bus.re_i && !fault) ? rd_val : '0;

    // ---------------- write path ----------------
    // Reset gates every write so a store in flight when reset rises is dropped.
    assign wr_en  = bus.we_i & ~fault & ~rst_i;
    assign ram_we = wr_en & is_ram;

    always_comb begin
        be    = 4'b0000;
        wlane = bus.wdata_i;
        case (bus.funct3_i)
            F3_B: begin
                be    = 4'b0001 << bus.addr_i[1:0];
                wlane = {4{bus.wdata_i[7:0]}};
            end
            F3_H: begin
                be    = bus.addr_i[1] ? 4'b1100 : 4'b0011;
                wlane = {2{bus.wdata_i[15:0]}};
            end
            F3_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // RAM has no reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    // A fault-free store to STATUS is a W1C; stores to CYCLE fall through.
    assign w1c = (wr_en && sel_st) ? bus.wdata_i[1:0] : 2'b00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q    <= '0;
            cycle_q  <= '0;
            status_q <= '0;
        end else begin
            cycle_q <= cycle_q + BITNESS'(1);
            if (wr_en && sel_out) out_q <= bus.wdata_i[7:0];
            // New faults are OR-ed in after the clear so set wins.
            status_q <= (status_q & ~w1c) | {bus_err, mis_err};
        end
    end

    assign mmio_out_o = out_q;
    assign status_o   = status_q;
endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [31:0] A_OUT = 32'hFFFF0000, A_CYC = 32'hFFFF0004, A_ST = 32'hFFFF0008;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_unit_if bus ();
    logic [7:0] mmio_out;
    logic [1:0] status;

    data_memory_unit dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .mmio_out_o (mmio_out),
        .status_o   (status)
    );

    typedef struct {
        string       nm;
        bit          c_acc;
        logic [31:0] rd;
        logic        flt;
        bit          c_reg;
        logic [7:0]  out;
        logic [1:0]  st;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // Monitor: every entry pushed during a cycle is checked at the following negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.c_acc) begin
                    checks++;
                    if (bus.rdata_o !== e.rd || bus.fault_o !== e.flt) begin
                        failures++;
                        $display("FAIL %s: rdata=%h fault=%b, expected rdata=%h fault=%b",
                                 e.nm, bus.rdata_o, bus.fault_o, e.rd, e.flt);
                    end
                end
                if (e.c_reg) begin
                    checks++;
                    if (mmio_out !== e.out || status !== e.st) begin
                        failures++;
                        $display("FAIL %s: out=%h status=%b, expected out=%h status=%b",
                                 e.nm, mmio_out, status, e.out, e.st);
                    end
                end
            end
        end
    end

    function automatic void push(string nm, bit ca, logic [31:0] rd, logic flt,
                                 bit cr, logic [7:0] o, logic [1:0] s);
        exp_t e;
        e.nm = nm; e.c_acc = ca; e.rd = rd; e.flt = flt;
        e.c_reg = cr; e.out = o; e.st = s;
        q.push_back(e);
    endfunction

    task automatic drive(logic we, logic re, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        bus.we_i = we; bus.re_i = re; bus.funct3_i = f3; bus.addr_i = a; bus.wdata_i = wd;
    endtask

    task automatic acc(string nm, logic we, logic re, logic [2:0] f3, logic [31:0] a,
                       logic [31:0] wd, logic [31:0] erd, logic eflt);
        @(posedge clk); #1;
        drive(we, re, f3, a, wd);
        push(nm, 1'b1, erd, eflt, 1'b0, 8'h00, 2'b00);
    endtask

    task automatic regs(string nm, logic [7:0] o, logic [1:0] s);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
        push(nm, 1'b0, 32'h0, 1'b0, 1'b1, o, s);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
        #2;
        drive(1'b0, 1'b1, LW, A_CYC, 32'h0);
        push("reset_state", 1'b1, 32'h0, 1'b0, 1'b1, 8'h00, 2'b00);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        drive(1'b0, 1'b0, LW, 32'h0, 32'h0);

        // Tenth rising edge after release: CYCLE reads 10.
        repeat (9) @(posedge clk);
        acc("cycle10",   1'b0, 1'b1, LW, A_CYC, 32'h0, 32'd10, 1'b0);

        acc("sw_beef",   1'b1, 1'b0, LW,  32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        acc("lw_beef",   1'b0, 1'b1, LW,  32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
        acc("lb_100",    1'b0, 1'b1, LB,  32'h100, 32'h0, 32'hFFFFFFEF, 1'b0);
        acc("lbu_103",   1'b0, 1'b1, LBU, 32'h103, 32'h0, 32'h000000DE, 1'b0);
        acc("lh_102",    1'b0, 1'b1, LH,  32'h102, 32'h0, 32'hFFFFDEAD, 1'b0);
        acc("lhu_100",   1'b0, 1'b1, LHU, 32'h100, 32'h0, 32'h0000BEEF, 1'b0);
        acc("sb_101",    1'b1, 1'b0, LB,  32'h101, 32'hFFFFFF12, 32'h0, 1'b0);
        acc("lw_after_sb", 1'b0, 1'b1, LW, 32'h100, 32'h0, 32'hDEAD12EF, 1'b0);
        acc("sh_102",    1'b1, 1'b0, LH,  32'h102, 32'hABCD5678, 32'h0, 1'b0);
        acc("lw_after_sh", 1'b0, 1'b1, LW, 32'h100, 32'h0, 32'h567812EF, 1'b0);
        acc("rd_before_wr", 1'b1, 1'b1, LW, 32'h100, 32'h11223344, 32'h567812EF, 1'b0);
        acc("lw_new",    1'b0, 1'b1, LW,  32'h100, 32'h0, 32'h11223344, 1'b0);
        acc("lb_101",    1'b0, 1'b1, LB,  32'h101, 32'h0, 32'h00000033, 1'b0);
        acc("lhu_102",   1'b0, 1'b1, LHU, 32'h102, 32'h0, 32'h00001122, 1'b0);
        acc("idle",      1'b0, 1'b0, LW,  32'h102, 32'h0, 32'h0, 1'b0);
        acc("idle_badf3", 1'b0, 1'b0, 3'b011, 32'h40000000, 32'h0, 32'h0, 1'b0);
        regs("idle_no_status", 8'h00, 2'b00);

        // Alignment faults
        acc("lw_mis",    1'b0, 1'b1, LW,  32'h102, 32'h0, 32'h0, 1'b1);
        regs("st_mis",   8'h00, 2'b01);
        acc("sw_mis",    1'b1, 1'b0, LW,  32'h101, 32'hCAFEF00D, 32'h0, 1'b1);
        acc("lh_mis",    1'b0, 1'b1, LH,  32'h103, 32'h0, 32'h0, 1'b1);
        acc("lw_unchg",  1'b0, 1'b1, LW,  32'h100, 32'h0, 32'h11223344, 1'b0);
        acc("w1c_mis",   1'b1, 1'b0, LW,  A_ST, 32'h1, 32'h0, 1'b0);
        regs("st_clr",   8'h00, 2'b00);

        // MMIO
        acc("out_sw",    1'b1, 1'b0, LW,  A_OUT, 32'h123456A5, 32'h0, 1'b0);
        regs("out_a5",   8'hA5, 2'b00);
        acc("out_sb",    1'b1, 1'b0, LB,  A_OUT, 32'h00000077, 32'h0, 1'b1);
        regs("out_keep", 8'hA5, 2'b10);
        acc("unmapped",  1'b0, 1'b1, LW,  32'h40000000, 32'h0, 32'h0, 1'b1);
        acc("mmio_off",  1'b0, 1'b1, LW,  32'hFFFF000C, 32'h0, 32'h0, 1'b1);
        acc("out_rd",    1'b0, 1'b1, LW,  A_OUT, 32'h0, 32'h000000A5, 1'b0);
        acc("st_rd",     1'b0, 1'b1, LW,  A_ST,  32'h0, 32'h00000002, 1'b0);
        acc("bad_f3",    1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1);
        acc("sw_top",    1'b1, 1'b0, LW,  32'h1FFFC, 32'h13579BDF, 32'h0, 1'b0);
        acc("lw_top",    1'b0, 1'b1, LW,  32'h1FFFC, 32'h0, 32'h13579BDF, 1'b0);
        acc("past_ram",  1'b0, 1'b1, LW,  32'h20000, 32'h0, 32'h0, 1'b1);
        acc("w1c_both",  1'b1, 1'b0, LW,  A_ST, 32'h3, 32'h0, 1'b0);
        regs("st_clr2",  8'hA5, 2'b00);

        // CYCLE wrap and write-ignore
        @(posedge clk); #1;
        force dut.cycle_q = 32'hFFFFFFFF;
        drive(1'b0, 1'b1, LW, A_CYC, 32'h0);
        push("cyc_max", 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 8'h00, 2'b00);
        @(negedge clk); #1;
        release dut.cycle_q;
        acc("cyc_wrap",  1'b0, 1'b1, LW,  A_CYC, 32'h0, 32'h0, 1'b0);
        acc("cyc_write", 1'b1, 1'b0, LW,  A_CYC, 32'h1234, 32'h0, 1'b0);
        acc("cyc_seq",   1'b0, 1'b1, LW,  A_CYC, 32'h0, 32'h2, 1'b0);
        regs("cyc_wr_nostat", 8'hA5, 2'b00);

        // Reset in the middle of a pending store
        acc("sw_200",    1'b1, 1'b0, LW,  32'h200, 32'h99, 32'h0, 1'b0);
        acc("lw_200",    1'b0, 1'b1, LW,  32'h200, 32'h0, 32'h99, 1'b0);
        acc("lh_mis2",   1'b0, 1'b1, LH,  32'h201, 32'h0, 32'h0, 1'b1);
        regs("pre_rst",  8'hA5, 2'b01);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, LW, 32'h200, 32'h55);
        #1 rst = 1'b1;
        #1 push("rst_async", 1'b0, 32'h0, 1'b0, 1'b1, 8'h00, 2'b00);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, LW, A_CYC, 32'h0);
        push("rst_cycle0", 1'b1, 32'h0, 1'b0, 1'b1, 8'h00, 2'b00);
        @(negedge clk); #2;
        rst = 1'b0;
        drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
        acc("lw_200_kept", 1'b0, 1'b1, LW, 32'h200, 32'h0, 32'h99, 1'b0);

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
